lsu_mem: RTL

- Load/store unit directly downstream of the 32-bit ALU: takes the ALU result as the effective byte address and performs one data-memory access per request.
- Generates word-aligned memory requests with byte write masks, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses.
- Sits between the execute stage and a data memory whose latency is variable, using a valid/ready request handshake and a req/ack memory handshake.

---
 rtl/lsu_mem.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem.sv
// Load/store unit between the execute stage and a variable-latency data memory.
// Accepts one access at a time, drives a held memory request, and returns an extended, registered response.
module lsu_mem #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             resp_valid,
    output logic             resp_we,
    output logic [4:0]       resp_rd,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             accept;
    logic             illegal;
    logic [1:0]       size;
    logic [3:0]       mask_next;
    logic [WIDTH-1:0] wdata_next;
    logic [WIDTH-1:0] load_data;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    logic             we_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       addr_lo_reg;
    logic [4:0]       rd_reg;
    logic [WIDTH-1:0] mem_addr_reg;
    logic [3:0]       mem_wmask_reg;
    logic [WIDTH-1:0] mem_wdata_reg;
    logic [WIDTH-1:0] resp_data_reg;
    logic             resp_err_reg;

    assign accept = req_valid && (state_reg == IDLE);
    assign size   = req_funct3[1:0];

    // Reserved size codes and misaligned halfword/word addresses never reach memory.
    always_comb begin
        illegal = 1'b0;
        unique case (req_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b001, 3'b101:         illegal = req_addr[0];
            3'b010:                 illegal = (req_addr[1:0] != 2'b00);
            default:                illegal = 1'b0;
        endcase
    end

    // Per-lane store data replication and byte enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign wdata_next[8*gi +: 8] =
                (size == 2'b00) ? req_wdata[7:0] :
                (size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                  req_wdata[8*gi +: 8];

            assign mask_next[gi] = req_we && (
                (size == 2'b10) ||
                ((size == 2'b01) && (req_addr[1] == LANE[1])) ||
                ((size == 2'b00) && (req_addr[1:0] == LANE)));
        end
    endgenerate

    // Little-endian lane selection from the latched low address bits.
    always_comb begin
        byte_sel  = mem_rdata[{addr_lo_reg, 3'b000} +: 8];
        half_sel  = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        unique case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = illegal ? RESP : MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_lo_reg   <= 2'b00;
            rd_reg        <= 5'd0;
            mem_addr_reg  <= '0;
            mem_wmask_reg <= 4'b0000;
            mem_wdata_reg <= '0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                we_reg        <= req_we;
                funct3_reg    <= req_funct3;
                addr_lo_reg   <= req_addr[1:0];
                rd_reg        <= req_rd;
                mem_addr_reg  <= {req_addr[WIDTH-1:2], 2'b00};
                mem_wmask_reg <= mask_next;
                mem_wdata_reg <= wdata_next;
                resp_err_reg  <= illegal;
                resp_data_reg <= '0;
            end
            if ((state_reg == MEM) && mem_ack) begin
                resp_data_reg <= we_reg ? '0 : load_data;
            end
        end
    end

    // Status outputs decode the state register directly so reset clears them without a clock.
    assign req_ready  = (state_reg == IDLE);
    assign mem_req    = (state_reg == MEM);
    assign mem_we     = mem_req && we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wmask  = mem_wmask_reg;
    assign mem_wdata  = mem_wdata_reg;

    assign resp_valid = (state_reg == RESP);
    assign resp_we    = resp_valid && we_reg;
    assign resp_rd    = resp_valid ? rd_reg : 5'd0;
    assign resp_data  = resp_valid ? resp_data_reg : '0;
    assign resp_err   = resp_valid && resp_err_reg;

endmodule
